// File: rtl/lmsm_pkg.sv
// Shared definitions for the load/store-multiple sequencer: default widths,
// register-index sizing and the sequencer state encoding.
package lmsm_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   // Eight architectural registers, so a 3-bit index and an 8-bit mask.
   localparam int IDX_W  = 3;
   localparam int MASK_W = 1 << IDX_W;
   // Transfer counter must reach MASK_W itself (0..8).
   localparam int CNT_W  = IDX_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_MEM,
      ST_WR_RF,
      ST_ADVANCE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Memory and register-file side of the sequencer. The master modport is the
// sequencer; the slave modport is the memory/register-file owner.
interface lmsm_sequencer_if
   import lmsm_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   // Memory access channel: request is held until ack.
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   // Register file: combinational read port, single write port.
   logic [IDX_W-1:0]  rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic [IDX_W-1:0]  rf_waddr;
   logic              rf_wen;
   logic [DATA_W-1:0] rf_wdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      output rf_raddr,
      input  rf_rdata,
      output rf_waddr, rf_wen, rf_wdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      input  rf_raddr,
      output rf_rdata,
      input  rf_waddr, rf_wen, rf_wdata
   );

endinterface

// File: rtl/lmsm_sequencer_lsb_encoder.sv
// Lowest-set-bit encoder: picks the next register to transfer so that
// transfers always run in ascending register order.
module lsb_encoder
   import lmsm_pkg::*;
(
   input  logic [MASK_W-1:0] mask,
   output logic [IDX_W-1:0]  index,
   output logic              valid
);

   // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
   always_comb begin
      // NOTE: every output gets a default before any condition; a path that
      // leaves a combinational output unassigned infers a latch.
      index = '0;
      valid = |mask;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer. Walks the selected registers in ascending
// order, moving one word per register between the register file and
// consecutive memory addresses starting at base_addr.
module lmsm_sequencer
   import lmsm_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [MASK_W-1:0] reg_list,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  xfer_count,
   lmsm_sequencer_if.master  bus
);

   state_t            state;
   state_t            state_next;

   logic              is_store_q;
   logic [MASK_W-1:0] mask_q;        // registers still to transfer
   logic [IDX_W-1:0]  idx_q;         // register of the transfer in flight
   logic [ADDR_W-1:0] addr_q;        // memory address of the transfer in flight
   logic [DATA_W-1:0] mem_wdata_q;   // store data captured from the RF
   logic [DATA_W-1:0] rf_wdata_q;    // load data captured from memory
   logic [CNT_W-1:0]  count_q;

   logic [IDX_W-1:0]  enc_idx;
   logic              enc_valid;
   logic [MASK_W-1:0] mask_clr;

   lsb_encoder u_lsb_encoder (
      .mask  (mask_q),
      .index (enc_idx),
      .valid (enc_valid)
   );

   // Remaining mask once the in-flight register is retired.
   assign mask_clr = mask_q & ~(MASK_W'(1) << idx_q);

   // State register; reset abandons any transfer in progress.
   always_ff @(posedge clk or posedge proc_rst) begin
      if (proc_rst) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block evaluation order.
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (reg_list != '0) ? ST_SELECT : ST_DONE;
            end
         end
         ST_SELECT: begin
            // An empty mask cannot reach SELECT; finishing is the safe exit.
            state_next = enc_valid ? ST_MEM : ST_DONE;
         end
         ST_MEM: begin
            if (bus.mem_ack) begin
               state_next = is_store_q ? ST_ADVANCE : ST_WR_RF;
            end
         end
         ST_WR_RF: begin
            state_next = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            state_next = (mask_clr == '0) ? ST_DONE : ST_SELECT;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand latching, data capture and per-transfer bookkeeping.
   always_ff @(posedge clk or posedge proc_rst) begin
      if (proc_rst) begin
         is_store_q  <= 1'b0;
         mask_q      <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         mem_wdata_q <= '0;
         rf_wdata_q  <= '0;
         count_q     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  is_store_q <= is_store;
                  mask_q     <= reg_list;
                  addr_q     <= base_addr;
                  count_q    <= '0;
               end
            end
            ST_SELECT: begin
               idx_q <= enc_idx;
               if (is_store_q) begin
                  mem_wdata_q <= bus.rf_rdata;
               end
            end
            ST_MEM: begin
               if (bus.mem_ack && !is_store_q) begin
                  rf_wdata_q <= bus.mem_rdata;
               end
            end
            ST_ADVANCE: begin
               mask_q  <= mask_clr;
               addr_q  <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
               count_q <= count_q + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are decoded from state so reset clears them in the same cycle.
   always_comb begin
      busy          = (state != ST_IDLE);
      done          = (state == ST_DONE);
      xfer_count    = count_q;
      bus.mem_req   = (state == ST_MEM);
      bus.mem_we    = (state == ST_MEM) && is_store_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.rf_wen    = (state == ST_WR_RF);
      bus.rf_waddr  = idx_q;
      bus.rf_wdata  = rf_wdata_q;
      // The RF read port shows the register being selected during SELECT.
      bus.rf_raddr  = (state == ST_SELECT) ? enc_idx : idx_q;
   end

endmodule
